// File: rtl/cpu_pkg.sv
// Shared CPU constants: register codes, datapath width and SP reset value.
// Used by the register file and by the ID-stage address decoders.
package cpu_pkg;

  localparam int          DATA_W  = 16;
  localparam logic [15:0] SP_INIT = 16'hBF00;
  localparam int          REG_NUM = 12;

  typedef logic [3:0] reg_code_t;

  localparam reg_code_t REG_SP = 4'd8;
  localparam reg_code_t REG_T  = 4'd9;
  localparam reg_code_t REG_IH = 4'd10;
  localparam reg_code_t REG_RA = 4'd11;

  // Codes 12-15 are reserved and map to no storage.
  function automatic logic is_reg(input reg_code_t code);
    return code < 4'(REG_NUM);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: ID read ports, WB write port, load tracking and hazard stall.
// master = pipeline side, slave = register file.
interface reg_file_sb_if;
  import cpu_pkg::*;

  reg_code_t          rd_addr1;
  reg_code_t          rd_addr2;
  logic               use1;
  logic               use2;
  logic [DATA_W-1:0]  rd_data1;
  logic [DATA_W-1:0]  rd_data2;
  logic               wr_en;
  reg_code_t          wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wb_is_load;
  logic               ld_issue;
  reg_code_t          ld_dest;
  logic               flush;
  logic               stall;
  logic [DATA_W-1:0]  ih_out;
  logic [DATA_W-1:0]  sp_out;

  modport master (
    output rd_addr1, rd_addr2, use1, use2, wr_en, wr_addr, wr_data,
           wb_is_load, ld_issue, ld_dest, flush,
    input  rd_data1, rd_data2, stall, ih_out, sp_out
  );

  modport slave (
    input  rd_addr1, rd_addr2, use1, use2, wr_en, wr_addr, wr_data,
           wb_is_load, ld_issue, ld_dest, flush,
    output rd_data1, rd_data2, stall, ih_out, sp_out
  );

endinterface

// File: rtl/load_scoreboard.sv
// Per-register pending-load counters and load-use stall generation.
// With REGFILE_BYPASS_EN, a final same-cycle load writeback releases the stall.
module load_scoreboard
  import cpu_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_code_t rd_addr1,
  input  reg_code_t rd_addr2,
  input  logic      use1,
  input  logic      use2,
  input  logic      wr_en,
  input  reg_code_t wr_addr,
  input  logic      wb_is_load,
  input  logic      ld_issue,
  input  reg_code_t ld_dest,
  input  logic      flush,
  output logic      stall
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [REG_NUM-1:0][PEND_W-1:0] pend_reg;
  logic [REG_NUM-1:0][PEND_W-1:0] pend_next;
  logic [REG_NUM-1:0]             busy;
  logic [REG_NUM-1:0]             inc_hit;
  logic [REG_NUM-1:0]             dec_hit;
  logic [REG_NUM-1:0]             resolves;
  logic [15:0]                    block;

  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_pend
      assign busy[gi]    = |pend_reg[gi];
      assign inc_hit[gi] = ld_issue && !stall && (ld_dest == 4'(gi));
      assign dec_hit[gi] = wr_en && wb_is_load && (wr_addr == 4'(gi)) && busy[gi];

      // Simultaneous issue and retire on one register cancel out.
      assign pend_next[gi] =
        (inc_hit[gi] && !dec_hit[gi] && pend_reg[gi] != PEND_MAX) ? pend_reg[gi] + 1'b1 :
        (dec_hit[gi] && !inc_hit[gi])                             ? pend_reg[gi] - 1'b1 :
                                                                    pend_reg[gi];

`ifdef REGFILE_BYPASS_EN
      // Raw ld_issue (not stall-gated) keeps this path free of a loop through stall.
      assign resolves[gi] = dec_hit[gi] && (pend_reg[gi] == PEND_W'(1)) &&
                            !(ld_issue && !flush && (ld_dest == 4'(gi)));
`else
      assign resolves[gi] = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // Reserved codes index the zero-extended upper bits and so never stall.
  assign block = 16'(busy & ~resolves);
  assign stall = (use1 & block[rd_addr1]) | (use2 & block[rd_addr2]);

endmodule

// File: rtl/reg_file_sb.sv
// CPU register file (R0-R7, SP, T, IH, RA) with load scoreboard.
// Build option REGFILE_BYPASS_EN: same-cycle WB write-through to the read ports.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  logic [DATA_W-1:0] regs_reg [REG_NUM];
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;
  logic              stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_reg[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (bus.wr_en && is_reg(bus.wr_addr)) begin
      regs_reg[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (is_reg(bus.rd_addr1)) rd1_val = regs_reg[bus.rd_addr1];
    if (is_reg(bus.rd_addr2)) rd2_val = regs_reg[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && is_reg(bus.wr_addr) && bus.wr_addr == bus.rd_addr1) rd1_val = bus.wr_data;
    if (bus.wr_en && is_reg(bus.wr_addr) && bus.wr_addr == bus.rd_addr2) rd2_val = bus.wr_data;
`endif
  end

  load_scoreboard #(
    .PEND_W (PEND_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1   (bus.rd_addr1),
    .rd_addr2   (bus.rd_addr2),
    .use1       (bus.use1),
    .use2       (bus.use2),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .wb_is_load (bus.wb_is_load),
    .ld_issue   (bus.ld_issue),
    .ld_dest    (bus.ld_dest),
    .flush      (bus.flush),
    .stall      (stall)
  );

  assign bus.rd_data1 = rd1_val;
  assign bus.rd_data2 = rd2_val;
  assign bus.stall    = stall;
  // Interrupt and debug views deliberately bypass nothing.
  assign bus.ih_out   = regs_reg[REG_IH];
  assign bus.sp_out   = regs_reg[REG_SP];

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, then random traffic vs a reference model.
// Works with or without REGFILE_BYPASS_EN defined.
module tb_reg_file_sb;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_sb_if bus();

  reg_file_sb #(.PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain register values and outstanding-load counts.
  logic [15:0] m_reg  [12];
  int          m_pend [12];

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a >= 12) return 16'h0000;
    if (BYP && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_reg[a];
  endfunction

  function automatic bit m_port_stall(input bit u, input logic [3:0] a);
    if (!u || a >= 12) return 1'b0;
    if (m_pend[a] == 0) return 1'b0;
    if (BYP && bus.wr_en && bus.wb_is_load && bus.wr_addr == a && m_pend[a] == 1 &&
        !(bus.ld_issue && !bus.flush && bus.ld_dest == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    return m_port_stall(bus.use1, bus.rd_addr1) | m_port_stall(bus.use2, bus.rd_addr2);
  endfunction

  task automatic m_edge(input bit st);
    bit inc, dec;
    if (rst) begin
      for (int i = 0; i < 12; i++) begin
        m_reg[i]  = (i == 8) ? 16'hBF00 : 16'h0000;
        m_pend[i] = 0;
      end
      return;
    end
    if (bus.flush) begin
      for (int i = 0; i < 12; i++) m_pend[i] = 0;
    end else begin
      inc = bus.ld_issue && bus.ld_dest < 12 && !st;
      dec = bus.wr_en && bus.wb_is_load && bus.wr_addr < 12 && m_pend[bus.wr_addr] > 0;
      if (!(inc && dec && bus.ld_dest == bus.wr_addr)) begin
        if (inc && m_pend[bus.ld_dest] < 3) m_pend[bus.ld_dest] = m_pend[bus.ld_dest] + 1;
        if (dec) m_pend[bus.wr_addr] = m_pend[bus.wr_addr] - 1;
      end
    end
    if (bus.wr_en && bus.wr_addr < 12) m_reg[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  // Directed vectors; m bits: 1=rd_data1 2=rd_data2 4=stall 8=ih_out 16=sp_out (vs eo).
  typedef struct {
    bit rst; bit [3:0] a1; bit u1; bit [3:0] a2; bit u2;
    bit we; bit [3:0] wa; bit [15:0] wd; bit wl;
    bit li; bit [3:0] ld; bit fl;
    bit [4:0] m; bit [15:0] e1; bit [15:0] e2; bit es; bit [15:0] eo;
  } vec_t;

  function automatic vec_t mk(
    input bit r, input bit [3:0] a1, input bit u1, input bit [3:0] a2, input bit u2,
    input bit we, input bit [3:0] wa, input bit [15:0] wd, input bit wl,
    input bit li, input bit [3:0] ld, input bit fl,
    input bit [4:0] m, input bit [15:0] e1, input bit [15:0] e2, input bit es, input bit [15:0] eo);
    vec_t v;
    v.rst = r; v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2;
    v.we = we; v.wa = wa; v.wd = wd; v.wl = wl;
    v.li = li; v.ld = ld; v.fl = fl;
    v.m = m; v.e1 = e1; v.e2 = e2; v.es = es; v.eo = eo;
    return v;
  endfunction

  vec_t vt[$];

  task automatic drive(input bit r, input bit [3:0] a1, input bit u1, input bit [3:0] a2,
                       input bit u2, input bit we, input bit [3:0] wa, input bit [15:0] wd,
                       input bit wl, input bit li, input bit [3:0] ld, input bit fl);
    rst = r; bus.rd_addr1 = a1; bus.use1 = u1; bus.rd_addr2 = a2; bus.use2 = u2;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wb_is_load = wl;
    bus.ld_issue = li; bus.ld_dest = ld; bus.flush = fl;
  endtask

  function automatic logic [3:0] rnd_code();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    bit st;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vt.push_back(mk(1, 0,0, 0,0,  0,0,16'h0,0,      0,0,0,  0,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(1, 0,0, 0,0,  0,0,16'h0,0,      0,0,0,  0,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 8,0, 3,0,  0,0,16'h0,0,      0,0,0,  23, 16'hBF00,16'h0,0,16'hBF00));
    vt.push_back(mk(0, 5,0, 0,0,  1,5,16'h1234,0,   0,0,0,  13, BYP ? 16'h1234 : 16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 5,0, 0,0,  1,5,16'hABCD,0,   0,0,0,  5,  BYP ? 16'hABCD : 16'h1234,16'h0,0,16'h0));
    vt.push_back(mk(0, 5,0, 13,0, 1,13,16'hFFFF,0,  0,0,0,  7,  16'hABCD,16'h0,0,16'h0));
    vt.push_back(mk(0, 5,0, 13,0, 0,0,16'h0,0,      0,0,0,  7,  16'hABCD,16'h0,0,16'h0));
    // load to R2, consumer waits, load writeback
    vt.push_back(mk(0, 2,1, 0,0,  0,0,16'h0,0,      1,2,0,  5,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 2,1, 0,0,  0,0,16'h0,0,      0,0,0,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 2,1, 0,0,  0,0,16'h0,0,      0,0,0,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 2,1, 0,0,  1,2,16'h00FF,1,   0,0,0,  5,  BYP ? 16'h00FF : 16'h0,16'h0,!BYP,16'h0));
    vt.push_back(mk(0, 2,1, 0,0,  0,0,16'h0,0,      0,0,0,  5,  16'h00FF,16'h0,0,16'h0));
    // two loads to IH
    vt.push_back(mk(0, 0,0, 0,0,  0,0,16'h0,0,      1,10,0, 4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 0,0, 0,0,  0,0,16'h0,0,      1,10,0, 4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 0,0, 10,1, 0,0,16'h0,0,      0,0,0,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 0,0, 10,1, 1,10,16'h1111,1,  0,0,0,  6,  16'h0,BYP ? 16'h1111 : 16'h0,1,16'h0));
    vt.push_back(mk(0, 0,0, 10,1, 1,10,16'h2222,1,  0,0,0,  6,  16'h0,BYP ? 16'h2222 : 16'h1111,!BYP,16'h0));
    vt.push_back(mk(0, 0,0, 10,1, 0,0,16'h0,0,      0,0,0,  14, 16'h0,16'h2222,0,16'h2222));
    // flush beats a same-cycle load issue
    vt.push_back(mk(0, 0,0, 0,0,  0,0,16'h0,0,      1,7,0,  4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 0,0, 7,1,  0,0,16'h0,0,      1,7,1,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 0,0, 7,1,  0,0,16'h0,0,      0,0,0,  4,  16'h0,16'h0,0,16'h0));
    // reset mid-stream with pend[1]=2, R1=5555
    vt.push_back(mk(0, 0,0, 0,0,  0,0,16'h0,0,      1,1,0,  4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 0,0, 0,0,  1,1,16'h5555,0,   1,1,0,  4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 1,1, 0,0,  0,0,16'h0,0,      0,0,0,  5,  16'h5555,16'h0,1,16'h0));
    vt.push_back(mk(1, 1,1, 0,0,  0,0,16'h0,0,      0,0,0,  5,  16'h5555,16'h0,1,16'h0));
    vt.push_back(mk(0, 1,1, 8,0,  0,0,16'h0,0,      0,0,0,  23, 16'h0,16'hBF00,0,16'hBF00));
    // four loads to R4 saturate at 3, then three retirements
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 0,0, 0,0, 0,0,16'h0,0,     1,4,0,  4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 4,1, 0,0,  1,4,16'h0444,1,   0,0,0,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 4,1, 0,0,  1,4,16'h0444,1,   0,0,0,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 4,1, 0,0,  1,4,16'h0444,1,   0,0,0,  4,  16'h0,16'h0,!BYP,16'h0));
    vt.push_back(mk(0, 4,1, 0,0,  0,0,16'h0,0,      0,0,0,  4,  16'h0,16'h0,0,16'h0));
    // same-cycle issue and retire on R6 leave the count unchanged
    vt.push_back(mk(0, 0,0, 0,0,  0,0,16'h0,0,      1,6,0,  4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 0,0, 0,0,  1,6,16'h0666,1,   1,6,0,  4,  16'h0,16'h0,0,16'h0));
    vt.push_back(mk(0, 6,1, 0,0,  0,0,16'h0,0,      0,0,0,  4,  16'h0,16'h0,1,16'h0));
    vt.push_back(mk(0, 6,1, 0,0,  1,6,16'h0777,1,   0,0,0,  4,  16'h0,16'h0,!BYP,16'h0));
    vt.push_back(mk(0, 6,1, 0,0,  0,0,16'h0,0,      0,0,0,  5,  16'h0777,16'h0,0,16'h0));

    @(posedge clk);
    #1;
    foreach (vt[k]) begin
      drive(vt[k].rst, vt[k].a1, vt[k].u1, vt[k].a2, vt[k].u2, vt[k].we, vt[k].wa,
            vt[k].wd, vt[k].wl, vt[k].li, vt[k].ld, vt[k].fl);
      #4;
      $display("[TB] vec %0d: a1=%0d a2=%0d d1=%h d2=%h stall=%0b", k,
               bus.rd_addr1, bus.rd_addr2, bus.rd_data1, bus.rd_data2, bus.stall);
      if (vt[k].m[0]) chk16($sformatf("vec%0d rd_data1", k), bus.rd_data1, vt[k].e1);
      if (vt[k].m[1]) chk16($sformatf("vec%0d rd_data2", k), bus.rd_data2, vt[k].e2);
      if (vt[k].m[2]) chk1 ($sformatf("vec%0d stall", k),    bus.stall,    vt[k].es);
      if (vt[k].m[3]) chk16($sformatf("vec%0d ih_out", k),   bus.ih_out,   vt[k].eo);
      if (vt[k].m[4]) chk16($sformatf("vec%0d sp_out", k),   bus.sp_out,   vt[k].eo);
      st = m_stall();
      @(posedge clk);
      m_edge(st);
      #1;
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) == 0), rnd_code(), 1'($urandom), rnd_code(), 1'($urandom),
            1'($urandom), rnd_code(), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0), rnd_code(), ($urandom_range(0, 15) == 0));
      #4;
      $display("[TB] rnd %0d: a1=%0d a2=%0d d1=%h d2=%h stall=%0b", n,
               bus.rd_addr1, bus.rd_addr2, bus.rd_data1, bus.rd_data2, bus.stall);
      chk16("rnd rd_data1", bus.rd_data1, m_read(bus.rd_addr1));
      chk16("rnd rd_data2", bus.rd_data2, m_read(bus.rd_addr2));
      chk1 ("rnd stall",    bus.stall,    m_stall());
      chk16("rnd ih_out",   bus.ih_out,   m_reg[10]);
      chk16("rnd sp_out",   bus.sp_out,   m_reg[8]);
      st = m_stall();
      @(posedge clk);
      m_edge(st);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Register file for the 16-bit five-stage CPU. It holds R0–R7 and the special registers SP, T, IH and RA.
- Consumes the 4-bit read-register codes produced by the ID-stage read-address decoders. Returns operand data to the ID/EX latch.
- Contains a load scoreboard that raises stall to hazard control when an operand is still being loaded.

Parameters:
- DATA_W, 16, register width.
- SP_INIT, 16'hBF00, reset value of SP.
- PEND_W, 2, width of each per-register pending-load counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- rd_addr1  in  4  read port 1 code: 0–7 = R0–R7, 8 = SP, 9 = T, 10 = IH, 11 = RA, 12–15 reserved
- rd_addr2  in  4  read port 2 code, same encoding
- use1  in  1  the ID instruction really consumes port 1
- use2  in  1  the ID instruction really consumes port 2
- rd_data1  out  16  port 1 data
- rd_data2  out  16  port 2 data
- wr_en  in  1  WB write enable
- wr_addr  in  4  WB destination code
- wr_data  in  16  WB data
- wb_is_load  in  1  the WB write is the result of a load
- ld_issue  in  1  a load enters EX this cycle
- ld_dest  in  4  destination code of that load
- flush  in  1  pipeline flush; clears the scoreboard
- stall  out  1  ID must hold (load-use hazard)
- ih_out  out  16  IH value for interrupt logic
- sp_out  out  16  SP value for debug display

Behaviour:
Storage and reset
- 12 registers of 16 bits.
- On rst: R0–R7, T, IH and RA go to 0; SP goes to SP_INIT; all pending counters go to 0.
- After reset: stall=0, and rd_data1/2 show the reset contents of the addressed registers.

Reads
- Combinational, zero latency, from the register array.
- Reserved codes 12–15 read 16'h0000.

Writes
- On the rising edge when wr_en=1 and wr_addr<12, wr_data is stored in the addressed register.
- Writes to 12–15 are ignored.
- Writes take effect from the next cycle.

Scoreboard
- One saturating PEND_W-bit counter per code 0–11.
- Each edge:
  - increment pend[ld_dest] if ld_issue=1, ld_dest<12 and stall=0;
  - decrement pend[wr_addr] if wr_en=1, wb_is_load=1 and the counter is nonzero.
- Increment and decrement on the same register in the same cycle: the counter is unchanged.
- Increment at 3 stays at 3. Decrement at 0 stays at 0.
- flush=1: all counters clear at the edge, and any ld_issue in that cycle is ignored. Precedence is rst > flush > inc/dec.

Stall
- stall = (use1 & pend[rd_addr1]≠0) | (use2 & pend[rd_addr2]≠0).
- Purely combinational from the registered counters.
- Reserved codes never stall.
- The pending check is made against the pre-edge counter value, so a load issued in cycle N stalls a consumer in ID from cycle N+1.
- Decrement case: a counter being decremented this cycle still reads its pre-edge value. With REGFILE_BYPASS_EN the bypass lets this resolve, as described under Optional Feature.

Outputs
- ih_out and sp_out are direct register contents.
- Not bypassed, in either configuration.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - If wr_en=1 and wr_addr==rd_addrX (X=1,2) with wr_addr<12, then rd_dataX=wr_data in the same cycle (write-through).
  - Stall for port X is also suppressed when the same-cycle writeback has wb_is_load=1, wr_addr==rd_addrX, and that writeback brings the counter to 0.
- Undefined:
  - Reads return the pre-write array value.
  - Stall uses the counters only, which costs one extra stall cycle per load-use.

Decomposition:
Shared package `cpu_pkg` holds:
- register codes REG_SP=4'd8, REG_T=4'd9, REG_IH=4'd10, REG_RA=4'd11, REG_NUM=12;
- DATA_W;
- SP_INIT.

The ID-stage decoders use the same codes. One sub-module is natural: `load_scoreboard`, which contains the counters, flush handling and stall generation. The array and bypass logic stay in the top level.

Test Plan:
- Reset with rst=1 for 2 cycles, then read rd_addr1=8, rd_addr2=3 -> rd_data1=16'hBF00, rd_data2=0, stall=0.
- Write R5=16'h1234, then R5=16'hABCD on consecutive edges; read code 5 each following cycle -> 16'h1234, then 16'hABCD. Write code 13=16'hFFFF -> reading 13 gives 0.
- ld_issue with ld_dest=2 at cycle 0, then use1=1, rd_addr1=2 -> stall=1 in cycles 1–2. At cycle 3 apply wr_en=1, wb_is_load=1, wr_addr=2, wr_data=16'h00FF:
  - with REGFILE_BYPASS_EN, stall=0 and rd_data1=16'h00FF at cycle 3;
  - without it, stall=1 at cycle 3 and 0 at cycle 4.
- Two loads to IH (code 10) back-to-back -> pend=2; one load writeback -> stall stays 1; second writeback -> stall=0, and ih_out equals the last wr_data.
- With pend[7]=1, assert flush together with ld_issue(ld_dest=7) -> next cycle pend[7]=0 and stall=0 for use2=1, rd_addr2=7.
- Assert rst mid-stream with pend[1]=2 and R1=16'h5555 -> after the edge R1=0, stall=0, and SP=16'hBF00.
